// File: rtl/countdown_timer.sv
// countdown_timer: minute/second countdown driven by one-hot push keys.
//
// While setTime is high the timer tracks number_min/number_sec (clamped to
// MAX_VAL) as both the preset and the displayed value. With setTime low,
// KEY 4'b1000 starts/pauses/resumes, and KEY 4'b0100 restarts from the preset.
// remain counts down once per CLK_PER_SEC cycles, and alarm is raised at 00:00.
//
// Ports:
//   CLK          system clock
//   RESETN       asynchronous active-low reset
//   setTime      setting mode; loads the preset every cycle
//   number_min   preset minutes (7 bits)
//   number_sec   preset seconds (7 bits)
//   KEY          one-hot keys: 4'b1000 start/pause, 4'b0100 restart
//   remain_min   remaining minutes
//   remain_sec   remaining seconds
//   running      high in RUN
//   alarm        high in DONE
//
// Optional feature macro: COUNTDOWN_BLINK_EN. When it is defined, alarm
// toggles every CLK_PER_SEC/2 cycles while in DONE. When it is undefined,
// alarm is held steady high for the whole DONE state.

module countdown_timer #(
  parameter int unsigned CLK_PER_SEC = 2000000,
  parameter int unsigned MAX_VAL     = 59
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       setTime,
  input  logic [6:0] number_min,
  input  logic [6:0] number_sec,
  input  logic [3:0] KEY,
  output logic [6:0] remain_min,
  output logic [6:0] remain_sec,
  output logic       running,
  output logic       alarm
);

  localparam int unsigned CntW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_PER_SEC - 1);
  localparam logic [6:0] MaxV = 7'(MAX_VAL);
`ifdef COUNTDOWN_BLINK_EN
  localparam int unsigned HalfSec = (CLK_PER_SEC >= 2) ? CLK_PER_SEC / 2 : 1;
  localparam logic [CntW-1:0] HalfMax = CntW'(HalfSec - 1);
`endif

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e          state_q, state_d;
  logic [6:0]      min_q, min_d, sec_q, sec_d;
  logic [6:0]      pre_min_q, pre_min_d, pre_sec_q, pre_sec_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            key_q, key_d;
  logic            running_q, running_d;
  logic            alarm_q, alarm_d;

  logic fire, start, restart;

  function automatic logic [6:0] clamp(input logic [6:0] x);
    return (x > MaxV) ? MaxV : x;
  endfunction

  // One action per press: only the 0->1 transition of key_pressed fires.
  assign key_d   = |KEY;
  assign fire    = key_d & ~key_q;
  assign start   = fire && (KEY == 4'b1000);
  assign restart = fire && (KEY == 4'b0100);

  always_comb begin
    state_d   = state_q;
    min_d     = min_q;
    sec_d     = sec_q;
    pre_min_d = pre_min_q;
    pre_sec_d = pre_sec_q;
    cnt_d     = cnt_q;

    if (setTime) begin
      pre_min_d = clamp(number_min);
      pre_sec_d = clamp(number_sec);
      min_d     = clamp(number_min);
      sec_d     = clamp(number_sec);
      state_d   = StIdle;
      cnt_d     = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && (min_q != 7'd0 || sec_q != 7'd0)) begin
            state_d = StRun;
            cnt_d   = '0;
          end
        end
        StRun: begin
          // A key action takes priority; a coincident tick is discarded.
          if (start) begin
            state_d = StPause;
          end else if (restart) begin
            min_d   = pre_min_q;
            sec_d   = pre_sec_q;
            cnt_d   = '0;
            state_d = StIdle;
          end else if (cnt_q == CntMax) begin
            cnt_d = '0;
            if (sec_q != 7'd0) begin
              sec_d = sec_q - 7'd1;
            end else if (min_q != 7'd0) begin
              min_d = min_q - 7'd1;
              sec_d = MaxV;
            end
            if (min_d == 7'd0 && sec_d == 7'd0) state_d = StDone;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StPause: begin
          if (start) begin
            state_d = StRun;
          end else if (restart) begin
            min_d   = pre_min_q;
            sec_d   = pre_sec_q;
            cnt_d   = '0;
            state_d = StIdle;
          end
        end
        StDone: begin
          if (start) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (restart) begin
            min_d   = pre_min_q;
            sec_d   = pre_sec_q;
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
`ifdef COUNTDOWN_BLINK_EN
            // CNT doubles as the half-second blink counter while in DONE.
            cnt_d = (cnt_q == HalfMax) ? '0 : cnt_q + 1'b1;
`else
            cnt_d = '0;
`endif
          end
        end
        default: state_d = StIdle;
      endcase
    end

    running_d = (state_d == StRun);
`ifdef COUNTDOWN_BLINK_EN
    if (state_d != StDone)      alarm_d = 1'b0;
    else if (state_q != StDone) alarm_d = 1'b1;
    else if (cnt_q == HalfMax)  alarm_d = ~alarm_q;
    else                        alarm_d = alarm_q;
`else
    alarm_d = (state_d == StDone);
`endif
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q   <= StIdle;
      min_q     <= '0;
      sec_q     <= '0;
      pre_min_q <= '0;
      pre_sec_q <= '0;
      cnt_q     <= '0;
      key_q     <= 1'b0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      pre_min_q <= pre_min_d;
      pre_sec_q <= pre_sec_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      running_q <= running_d;
      alarm_q   <= alarm_d;
    end
  end

  assign remain_min = min_q;
  assign remain_sec = sec_q;
  assign running    = running_q;
  assign alarm      = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer with CLK_PER_SEC=10.
module tb_countdown_timer;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic       setTime = 1'b0;
  logic [6:0] number_min = '0;
  logic [6:0] number_sec = '0;
  logic [3:0] KEY = '0;
  logic [6:0] remain_min, remain_sec;
  logic       running, alarm;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  countdown_timer #(
    .CLK_PER_SEC(10),
    .MAX_VAL    (59)
  ) u_dut (
    .CLK       (CLK),
    .RESETN    (RESETN),
    .setTime   (setTime),
    .number_min(number_min),
    .number_sec(number_sec),
    .KEY       (KEY),
    .remain_min(remain_min),
    .remain_sec(remain_sec),
    .running   (running),
    .alarm     (alarm)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n active edges, then settle 1 time unit past the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // KEY is sampled on one edge, then released.
  task automatic press(input logic [3:0] k);
    KEY = k;
    tick(1);
    KEY = 4'b0000;
  endtask

  task automatic load(input logic [6:0] m, input logic [6:0] s);
    setTime    = 1'b1;
    number_min = m;
    number_sec = s;
    tick(1);
    setTime = 1'b0;
  endtask

  initial begin
    // 1. Reset holds even with keys and setTime active.
    KEY = 4'b1000; setTime = 1'b1; number_min = 7'd5; number_sec = 7'd5;
    tick(3);
    check("rst_min", remain_min, 0);
    check("rst_sec", remain_sec, 0);
    check("rst_running", running, 0);
    check("rst_alarm", alarm, 0);
    KEY = 4'b0000; setTime = 1'b0;
    RESETN = 1'b1;
    tick(2);
    check("post_rst_running", running, 0);
    check("post_rst_sec", remain_sec, 0);

    // 2. Load 01:02 and count down to DONE.
    load(7'd1, 7'd2);
    check("load_min", remain_min, 1);
    check("load_sec", remain_sec, 2);
    press(4'b1000);                       // entry edge E0
    check("run_entry", running, 1);
    tick(9);
    check("e9_sec", remain_sec, 2);
    tick(1);
    check("e10_sec", remain_sec, 1);
    check("e10_min", remain_min, 1);
    tick(10);
    check("e20_sec", remain_sec, 0);
    check("e20_min", remain_min, 1);
    tick(10);
    check("e30_min", remain_min, 0);
    check("e30_sec", remain_sec, 59);
    tick(589);
    check("e619_sec", remain_sec, 1);
    check("e619_alarm", alarm, 0);
    tick(1);
    check("e620_sec", remain_sec, 0);
    check("e620_alarm", alarm, 1);
    check("e620_running", running, 0);
    tick(5);
`ifdef COUNTDOWN_BLINK_EN
    check("blink_low", alarm, 0);
`else
    check("alarm_hold5", alarm, 1);
`endif
    tick(5);
    check("alarm_e630", alarm, 1);
    check("done_running", running, 0);
    press(4'b1000);
    check("done_start_alarm", alarm, 0);
    check("done_start_sec", remain_sec, 0);
    press(4'b1000);                        // 00:00 in IDLE: no start
    check("idle_zero_start", running, 0);

    // 3. Clamp, zero start, non-one-hot key.
    load(7'd75, 7'd99);
    check("clamp_min", remain_min, 59);
    check("clamp_sec", remain_sec, 59);
    load(7'd0, 7'd0);
    press(4'b1000);
    check("zero_start_running", running, 0);
    load(7'd0, 7'd5);
    press(4'b1100);
    tick(1);
    check("multi_key_running", running, 0);

    // 4. Pause at CNT=4 from 00:05, hold 50 cycles, resume.
    press(4'b1000);                        // E0, CNT=0
    check("p_run", running, 1);
    tick(4);                               // CNT=4
    press(4'b1000);                        // pauses on E5
    check("pause_running", running, 0);
    check("pause_sec", remain_sec, 5);
    tick(50);
    check("pause_hold_sec", remain_sec, 5);
    check("pause_hold_running", running, 0);
    press(4'b1000);                        // resume edge R, CNT stays 4
    check("resume_running", running, 1);
    tick(5);
    check("resume_r5", remain_sec, 5);
    tick(1);
    check("resume_r6", remain_sec, 4);

    // 5. Restart colliding with tick completion.
    tick(10);
    check("r16_sec", remain_sec, 3);
    tick(9);                               // CNT=9
    press(4'b0100);
    check("restart_sec", remain_sec, 5);
    check("restart_min", remain_min, 0);
    check("restart_running", running, 0);
    tick(10);
    check("restart_idle_static", remain_sec, 5);

    // Holding start for 100 edges fires once.
    load(7'd2, 7'd0);
    KEY = 4'b1000;
    tick(100);
    check("hold_running", running, 1);
    check("hold_min", remain_min, 1);
    check("hold_sec", remain_sec, 51);
    KEY = 4'b0000;

    // 6. setTime mid-run.
    setTime = 1'b1; number_min = 7'd3; number_sec = 7'd7;
    tick(1);
    check("st_running", running, 0);
    check("st_alarm", alarm, 0);
    check("st_min", remain_min, 3);
    check("st_sec", remain_sec, 7);
    number_min = 7'd4; number_sec = 7'd8;
    KEY = 4'b1000;                         // ignored while setting
    tick(1);
    check("st_track_min", remain_min, 4);
    check("st_track_sec", remain_sec, 8);
    check("st_key_ignored", running, 0);
    setTime = 1'b0;
    tick(1);
    KEY = 4'b0000;
    tick(20);
    check("st_static_sec", remain_sec, 8);
    check("st_static_running", running, 0);

    // Asynchronous reset honoured mid-count.
    press(4'b1000);
    tick(15);
    check("pre_rst_sec", remain_sec, 7);
    #2 RESETN = 1'b0;
    #1;
    check("async_rst_min", remain_min, 0);
    check("async_rst_sec", remain_sec, 0);
    check("async_rst_running", running, 0);
    tick(1);
    RESETN = 1'b1;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Consumer of the minute/second value produced by the time-setting block. While setTime is high it tracks number_min/number_sec as the preset. Otherwise KEY presses start, pause and restart a countdown, decremented once per second. At 00:00 it raises an alarm output, which drives the 7-segment/LED logic.

Parameters:
CLK_PER_SEC, 2000000, CLK cycles per one-second tick (use 10 in simulation).
MAX_VAL, 59, upper limit for minutes and seconds; inputs above it are clamped.

Ports:
CLK  input  1  system clock
RESETN  input  1  asynchronous active-low reset
setTime  input  1  high = setting mode; timer loads the preset
number_min  input  7  preset minutes from the time-setting block
number_sec  input  7  preset seconds from the time-setting block
KEY  input  4  one-hot push keys, active high: 4'b1000 start/pause, 4'b0100 restart
remain_min  output  7  remaining minutes
remain_sec  output  7  remaining seconds
running  output  1  high in RUN state
alarm  output  1  high in DONE state

Behaviour:
- Reset is asynchronous on RESETN low and is honoured mid-count. On reset:
  - state=IDLE
  - remain_min=0, remain_sec=0
  - preset=0
  - tick CNT=0
  - key_pressed=0
  - running=0, alarm=0
- States are IDLE, RUN, PAUSE and DONE. running and alarm are registered and decoded from state.
- Key edge detection:
  - key_pressed is set on the first cycle KEY is nonzero.
  - key_pressed is cleared on the first cycle KEY==0.
  - An action fires only on the cycle key_pressed goes 0->1, so one action per press.
  - Non-one-hot or unlisted KEY values set key_pressed but fire no action.
- setTime high overrides everything, every cycle:
  - preset and remain are loaded with clamp(number_min) and clamp(number_sec), where clamp(x) = x>MAX_VAL ? MAX_VAL : x.
  - state=IDLE, CNT=0.
  - KEY actions are ignored; key_pressed is still tracked.
- With setTime low, transitions are:
  - IDLE, start: if remain==00:00, stay IDLE. Otherwise go to RUN and set CNT=0.
  - RUN, start: go to PAUSE; CNT holds.
  - PAUSE, start: go to RUN; CNT resumes from its held value.
  - RUN/PAUSE/DONE, restart: remain=preset, CNT=0, state=IDLE.
  - DONE, start: go to IDLE; remain stays 00:00.
- Tick in RUN:
  - CNT increments each cycle.
  - When CNT==CLK_PER_SEC-1, CNT returns to 0 and the count decrements on that same edge:
    - sec>0: sec-1.
    - sec==0 and min>0: min-1, sec=MAX_VAL.
  - When the decrement yields 00:00, the state goes to DONE on the same edge.
  - The first decrement occurs exactly CLK_PER_SEC cycles after entering RUN from IDLE.
- A key action and a tick completion in the same cycle: the key action wins. The tick is discarded and remain is not decremented.
- setTime rising during RUN: IDLE on the next edge, alarm drops, remain shows the new preset.
- Counters never underflow. In IDLE, PAUSE and DONE, remain is static unless setTime is high or restart fires.

Optional Feature:
COUNTDOWN_BLINK_EN
- Defined: in DONE, alarm toggles every CLK_PER_SEC/2 cycles (1 Hz blink).
  - alarm starts high on entry to DONE, reusing CNT as the half-second counter.
  - running stays 0 throughout DONE.
- Undefined: alarm is held steady high for the whole DONE state; CNT stays 0 in DONE.

Test Plan:
1. Reset: RESETN low with KEY=4'b1000 and setTime=1 -> remain=00:00, running=0, alarm=0. Release reset -> still IDLE.
2. Load and count (CLK_PER_SEC=10):
   - setTime=1 with min=1, sec=2, then setTime=0 and press 4'b1000.
   - remain reads 01:01 exactly 10 cycles after entry to RUN, then 01:00 after 20 cycles.
   - 00:59 after 30 cycles (min borrow).
   - DONE with alarm=1 after 620 cycles.
3. Clamp and zero start:
   - setTime=1 with min=75, sec=99 -> remain=59:59.
   - Load 00:00, press start -> stays IDLE, running=0.
4. Pause/resume:
   - Start from 00:05, press 4'b1000 at CNT=4 -> PAUSE; remain and CNT frozen for 50 cycles.
   - Press again -> first decrement 6 cycles later.
5. Restart and collision:
   - From RUN at 00:03, press 4'b0100 on the cycle CNT==9 -> remain=preset 00:05, state IDLE, no decrement.
   - Holding KEY for 100 cycles fires exactly one action.
6. setTime mid-run and alarm:
   - Raise setTime during RUN -> IDLE next edge, remain tracks inputs.
   - In DONE with COUNTDOWN_BLINK_EN defined -> alarm period 10 cycles. Undefined -> alarm constant 1 until start clears it to IDLE.
